// File: rtl/rf_writeback_queue.sv
// Register-file writeback queue: FIFO of (reg, data) writes drained one per cycle,
// with pending-write lookup for two read ports. Define RF_WB_FORWARD_EN to forward lookup data.
module rf_writeback_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    in_reg,
    input  logic [31:0]   in_data,
    input  logic          rf_stall,
    output logic          rf_write_en,
    output logic [4:0]    rf_write_reg,
    output logic [31:0]   rf_write_data,
    input  logic [4:0]    look_reg_1,
    input  logic [4:0]    look_reg_2,
    output logic          look_hit_1,
    output logic          look_hit_2,
    output logic [31:0]   look_data_1,
    output logic [31:0]   look_data_2,
    output logic [AW:0]   count
);

    logic [4:0]    fifo_reg_mem  [DEPTH];
    logic [31:0]   fifo_data_mem [DEPTH];
    logic [AW-1:0] head_reg;
    logic [AW-1:0] tail_reg;
    logic [AW:0]   count_reg;
    logic          rf_write_en_reg;
    logic [4:0]    rf_write_reg_reg;
    logic [31:0]   rf_write_data_reg;

    logic push;
    logic pop;

    // Writes to $0 are accepted but dropped, so they never occupy a slot.
    assign in_ready = (count_reg != (AW+1)'(DEPTH));
    assign push     = in_valid && in_ready && (in_reg != 5'd0);
    assign pop      = !rf_stall && (count_reg != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_reg_mem[tail_reg]  <= in_reg;
            fifo_data_mem[tail_reg] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg          <= '0;
            tail_reg          <= '0;
            count_reg         <= '0;
            rf_write_en_reg   <= 1'b0;
            rf_write_reg_reg  <= 5'd0;
            rf_write_data_reg <= 32'd0;
        end else begin
            if (push) begin
                tail_reg <= tail_reg + 1'b1;
            end
            if (pop) begin
                head_reg <= head_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            // A stalled output stage holds everything, including the strobe.
            if (!rf_stall) begin
                if (pop) begin
                    rf_write_en_reg   <= 1'b1;
                    rf_write_reg_reg  <= fifo_reg_mem[head_reg];
                    rf_write_data_reg <= fifo_data_mem[head_reg];
                end else begin
                    rf_write_en_reg   <= 1'b0;
                end
            end
        end
    end

    assign rf_write_en   = rf_write_en_reg;
    assign rf_write_reg  = rf_write_reg_reg;
    assign rf_write_data = rf_write_data_reg;
    assign count         = count_reg;

    logic [4:0] look_reg_arr [2];
    logic       look_hit_arr [2];

    assign look_reg_arr[0] = look_reg_1;
    assign look_reg_arr[1] = look_reg_2;

`ifdef RF_WB_FORWARD_EN
    logic [31:0] look_data_arr [2];
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_look
            logic [AW-1:0] slot;
`ifdef RF_WB_FORWARD_EN
            logic [31:0]   data_sel;
`endif
            // Scan oldest to youngest so the last match seen is the youngest;
            // the output stage is older than every FIFO entry.
            always_comb begin
                slot     = head_reg;
                look_hit_arr[gi] = 1'b0;
`ifdef RF_WB_FORWARD_EN
                data_sel = 32'd0;
`endif
                if (rf_write_en_reg && (rf_write_reg_reg == look_reg_arr[gi])) begin
                    look_hit_arr[gi] = 1'b1;
`ifdef RF_WB_FORWARD_EN
                    data_sel = rf_write_data_reg;
`endif
                end
                for (int k = 0; k < DEPTH; k++) begin
                    slot = head_reg + AW'(k);
                    if (((AW+1)'(k) < count_reg) && (fifo_reg_mem[slot] == look_reg_arr[gi])) begin
                        look_hit_arr[gi] = 1'b1;
`ifdef RF_WB_FORWARD_EN
                        data_sel = fifo_data_mem[slot];
`endif
                    end
                end
                if (look_reg_arr[gi] == 5'd0) begin
                    look_hit_arr[gi] = 1'b0;
`ifdef RF_WB_FORWARD_EN
                    data_sel = 32'd0;
`endif
                end
            end
`ifdef RF_WB_FORWARD_EN
            assign look_data_arr[gi] = data_sel;
`endif
        end
    endgenerate

    assign look_hit_1 = look_hit_arr[0];
    assign look_hit_2 = look_hit_arr[1];

`ifdef RF_WB_FORWARD_EN
    assign look_data_1 = look_data_arr[0];
    assign look_data_2 = look_data_arr[1];
`else
    assign look_data_1 = 32'd0;
    assign look_data_2 = 32'd0;
`endif

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Directed, table-driven bench for rf_writeback_queue (DEPTH=4): each vector
// drives inputs for one clock and checks all outputs after that edge.
module tb_rf_writeback_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_reg;
    logic [31:0] in_data;
    logic        rf_stall;
    logic        rf_write_en;
    logic [4:0]  rf_write_reg;
    logic [31:0] rf_write_data;
    logic [4:0]  look_reg_1;
    logic [4:0]  look_reg_2;
    logic        look_hit_1;
    logic        look_hit_2;
    logic [31:0] look_data_1;
    logic [31:0] look_data_2;
    logic [2:0]  count;

    int vectors_applied = 0;
    int miscompares     = 0;

    always #5 clk = ~clk;

    rf_writeback_queue #(.DEPTH(4), .AW(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg), .in_data(in_data),
        .rf_stall(rf_stall),
        .rf_write_en(rf_write_en), .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data),
        .look_reg_1(look_reg_1), .look_reg_2(look_reg_2),
        .look_hit_1(look_hit_1), .look_hit_2(look_hit_2),
        .look_data_1(look_data_1), .look_data_2(look_data_2),
        .count(count)
    );

    typedef struct {
        logic        rst;
        logic        vld;
        logic [4:0]  rg;
        logic [31:0] dat;
        logic        stall;
        logic [4:0]  l1;
        logic [4:0]  l2;
        logic        en;
        logic [4:0]  wreg;
        logic [31:0] wdat;
        logic [2:0]  cnt;
        logic        rdy;
        logic        h1;
        logic [31:0] d1;
        logic        h2;
        logic [31:0] d2;
    } vec_t;

    function automatic vec_t mk(logic r, logic v, logic [4:0] rg, logic [31:0] dat, logic st,
                                logic [4:0] l1, logic [4:0] l2, logic en, logic [4:0] wreg,
                                logic [31:0] wdat, logic [2:0] cnt, logic rdy,
                                logic h1, logic [31:0] d1, logic h2, logic [31:0] d2);
        vec_t t;
        t.rst = r; t.vld = v; t.rg = rg; t.dat = dat; t.stall = st;
        t.l1 = l1; t.l2 = l2; t.en = en; t.wreg = wreg; t.wdat = wdat;
        t.cnt = cnt; t.rdy = rdy; t.h1 = h1; t.d1 = d1; t.h2 = h2; t.d2 = d2;
        return t;
    endfunction

    // Forwarded data is only visible when the forwarding build is selected.
    function automatic logic [31:0] fwd(logic [31:0] x);
`ifdef RF_WB_FORWARD_EN
        return x;
`else
        return 32'd0 & x;
`endif
    endfunction

    task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL vec %0d %s: got %h expected %h", idx, nm, act, exp);
        end
    endtask

    task automatic apply(vec_t t, int idx);
        @(negedge clk);
        rst = t.rst; in_valid = t.vld; in_reg = t.rg; in_data = t.dat;
        rf_stall = t.stall; look_reg_1 = t.l1; look_reg_2 = t.l2;
        @(posedge clk);
        #1;
        vectors_applied++;
        chk("rf_write_en",   idx, 32'(rf_write_en),   32'(t.en));
        chk("rf_write_reg",  idx, 32'(rf_write_reg),  32'(t.wreg));
        chk("rf_write_data", idx, rf_write_data,      t.wdat);
        chk("count",         idx, 32'(count),         32'(t.cnt));
        chk("in_ready",      idx, 32'(in_ready),      32'(t.rdy));
        chk("look_hit_1",    idx, 32'(look_hit_1),    32'(t.h1));
        chk("look_data_1",   idx, look_data_1,        fwd(t.d1));
        chk("look_hit_2",    idx, 32'(look_hit_2),    32'(t.h2));
        chk("look_data_2",   idx, look_data_2,        fwd(t.d2));
        $display("vec %0d: rst=%0b v=%0b r%0d=%h stall=%0b -> en=%0b r%0d=%h cnt=%0d rdy=%0b hit=%0b/%0b",
                 idx, t.rst, t.vld, t.rg, t.dat, t.stall, rf_write_en, rf_write_reg,
                 rf_write_data, count, in_ready, look_hit_1, look_hit_2);
    endtask

    vec_t vecs [32];

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_reg = 5'd0; in_data = 32'd0;
        rf_stall = 1'b0; look_reg_1 = 5'd0; look_reg_2 = 5'd0;
        repeat (2) @(posedge clk);

        //             rst v  rg  dat           st l1  l2  en wreg wdat          c  rdy h1 d1            h2 d2
        vecs[0]  = mk(0, 0, 0,  32'h0,        0, 0,  0,  0, 0,  32'h0,        0, 1, 0, 32'h0,        0, 32'h0);
        vecs[1]  = mk(0, 1, 5,  32'hDEADBEEF, 0, 5,  0,  0, 0,  32'h0,        1, 1, 1, 32'hDEADBEEF, 0, 32'h0);
        vecs[2]  = mk(0, 0, 0,  32'h0,        0, 5,  0,  1, 5,  32'hDEADBEEF, 0, 1, 1, 32'hDEADBEEF, 0, 32'h0);
        vecs[3]  = mk(0, 0, 0,  32'h0,        0, 5,  0,  0, 5,  32'hDEADBEEF, 0, 1, 0, 32'h0,        0, 32'h0);
        vecs[4]  = mk(0, 1, 1,  32'h1,        1, 0,  0,  0, 5,  32'hDEADBEEF, 1, 1, 0, 32'h0,        0, 32'h0);
        vecs[5]  = mk(0, 1, 2,  32'h2,        1, 0,  0,  0, 5,  32'hDEADBEEF, 2, 1, 0, 32'h0,        0, 32'h0);
        vecs[6]  = mk(0, 1, 3,  32'h3,        1, 0,  0,  0, 5,  32'hDEADBEEF, 3, 1, 0, 32'h0,        0, 32'h0);
        vecs[7]  = mk(0, 1, 4,  32'h4,        1, 0,  0,  0, 5,  32'hDEADBEEF, 4, 0, 0, 32'h0,        0, 32'h0);
        vecs[8]  = mk(0, 1, 9,  32'h99,       1, 4,  9,  0, 5,  32'hDEADBEEF, 4, 0, 1, 32'h4,        0, 32'h0);
        vecs[9]  = mk(0, 0, 0,  32'h0,        0, 1,  0,  1, 1,  32'h1,        3, 1, 1, 32'h1,        0, 32'h0);
        vecs[10] = mk(0, 0, 0,  32'h0,        0, 2,  0,  1, 2,  32'h2,        2, 1, 1, 32'h2,        0, 32'h0);
        vecs[11] = mk(0, 0, 0,  32'h0,        0, 3,  0,  1, 3,  32'h3,        1, 1, 1, 32'h3,        0, 32'h0);
        vecs[12] = mk(0, 0, 0,  32'h0,        0, 4,  0,  1, 4,  32'h4,        0, 1, 1, 32'h4,        0, 32'h0);
        vecs[13] = mk(0, 0, 0,  32'h0,        0, 4,  0,  0, 4,  32'h4,        0, 1, 0, 32'h0,        0, 32'h0);
        vecs[14] = mk(0, 1, 0,  32'h1234,     0, 0,  0,  0, 4,  32'h4,        0, 1, 0, 32'h0,        0, 32'h0);
        vecs[15] = mk(0, 0, 0,  32'h0,        0, 0,  0,  0, 4,  32'h4,        0, 1, 0, 32'h0,        0, 32'h0);
        vecs[16] = mk(0, 1, 7,  32'h11,       1, 7,  7,  0, 4,  32'h4,        1, 1, 1, 32'h11,       1, 32'h11);
        vecs[17] = mk(0, 1, 7,  32'h22,       1, 7,  7,  0, 4,  32'h4,        2, 1, 1, 32'h22,       1, 32'h22);
        vecs[18] = mk(0, 0, 0,  32'h0,        1, 7,  7,  0, 4,  32'h4,        2, 1, 1, 32'h22,       1, 32'h22);
        vecs[19] = mk(0, 1, 8,  32'h88,       0, 7,  8,  1, 7,  32'h11,       2, 1, 1, 32'h22,       1, 32'h88);
        vecs[20] = mk(0, 0, 0,  32'h0,        0, 7,  8,  1, 7,  32'h22,       1, 1, 1, 32'h22,       1, 32'h88);
        vecs[21] = mk(0, 0, 0,  32'h0,        0, 7,  8,  1, 8,  32'h88,       0, 1, 0, 32'h0,        1, 32'h88);
        vecs[22] = mk(0, 0, 0,  32'h0,        0, 7,  8,  0, 8,  32'h88,       0, 1, 0, 32'h0,        0, 32'h0);
        vecs[23] = mk(0, 1, 10, 32'hA0,       1, 0,  0,  0, 8,  32'h88,       1, 1, 0, 32'h0,        0, 32'h0);
        vecs[24] = mk(0, 1, 11, 32'hA1,       1, 0,  0,  0, 8,  32'h88,       2, 1, 0, 32'h0,        0, 32'h0);
        vecs[25] = mk(0, 1, 12, 32'hA2,       1, 0,  0,  0, 8,  32'h88,       3, 1, 0, 32'h0,        0, 32'h0);
        vecs[26] = mk(0, 1, 13, 32'hA3,       1, 0,  0,  0, 8,  32'h88,       4, 0, 0, 32'h0,        0, 32'h0);
        vecs[27] = mk(0, 1, 14, 32'hEE,       0, 14, 13, 1, 10, 32'hA0,       3, 1, 0, 32'h0,        1, 32'hA3);
        vecs[28] = mk(0, 0, 0,  32'h0,        0, 0,  0,  1, 11, 32'hA1,       2, 1, 0, 32'h0,        0, 32'h0);
        vecs[29] = mk(0, 0, 0,  32'h0,        0, 0,  0,  1, 12, 32'hA2,       1, 1, 0, 32'h0,        0, 32'h0);
        vecs[30] = mk(0, 0, 0,  32'h0,        0, 0,  0,  1, 13, 32'hA3,       0, 1, 0, 32'h0,        0, 32'h0);
        vecs[31] = mk(0, 0, 0,  32'h0,        0, 0,  0,  0, 13, 32'hA3,       0, 1, 0, 32'h0,        0, 32'h0);

        for (int i = 0; i < 32; i++) begin
            apply(vecs[i], i);
        end

        // Reset in the middle of a drain discards everything queued.
        apply(mk(0, 1, 20, 32'h20, 1, 0,  0,  0, 13, 32'hA3, 1, 1, 0, 32'h0,  0, 32'h0), 100);
        apply(mk(0, 1, 21, 32'h21, 1, 0,  0,  0, 13, 32'hA3, 2, 1, 0, 32'h0,  0, 32'h0), 101);
        apply(mk(0, 1, 22, 32'h22, 1, 0,  0,  0, 13, 32'hA3, 3, 1, 0, 32'h0,  0, 32'h0), 102);
        apply(mk(0, 0, 0,  32'h0,  0, 21, 22, 1, 20, 32'h20, 2, 1, 1, 32'h21, 1, 32'h22), 103);
        apply(mk(1, 0, 0,  32'h0,  0, 21, 22, 0, 0,  32'h0,  0, 1, 0, 32'h0,  0, 32'h0), 104);
        apply(mk(0, 0, 0,  32'h0,  0, 21, 22, 0, 0,  32'h0,  0, 1, 0, 32'h0,  0, 32'h0), 105);

        // Post-reset push drains normally; a stall holds an asserted strobe.
        apply(mk(0, 1, 6,  32'h66, 0, 6,  0,  0, 0,  32'h0,  1, 1, 1, 32'h66, 0, 32'h0), 106);
        apply(mk(0, 0, 0,  32'h0,  0, 6,  0,  1, 6,  32'h66, 0, 1, 1, 32'h66, 0, 32'h0), 107);
        apply(mk(0, 0, 0,  32'h0,  1, 6,  0,  1, 6,  32'h66, 0, 1, 1, 32'h66, 0, 32'h0), 108);
        apply(mk(0, 0, 0,  32'h0,  0, 6,  0,  0, 6,  32'h66, 0, 1, 0, 32'h0,  0, 32'h0), 109);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
